// File: rtl/rr_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_decoder_arbiter
// Purpose  : Four-master round-robin arbiter driving the 2-to-4 decoder fabric.
// Revision : 1.0 - initial release
// ============================================================================
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:3] req,
  input  logic       done,
  output logic [0:3] grant,
  output logic [1:0] address,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value on the final permitted hold cycle; unused when the limit is off.
  localparam logic [7:0] C_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic [0:3] grant_q, grant_d;
  logic [1:0] address_q, address_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       limit_hit;
  logic       normal_rel;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    address_d  = address_q;
    timeout_d  = 1'b0;
    found      = 1'b0;
    winner     = ptr_q;
    cand       = ptr_q;

    // Rotating search starting at the priority pointer; 2-bit add wraps naturally.
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    limit_hit  = (MAX_HOLD != 0) && (cnt_q == C_HOLD_LAST);
    normal_rel = done || !req[owner_q];

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = GRANT;
          owner_d         = winner;
          address_d       = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          cnt_d           = 8'd0;
        end
      end
      GRANT: begin
        if (normal_rel || limit_hit) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = owner_q + 2'd1;
          timeout_d = limit_hit && !normal_rel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      cnt_q     <= 8'd0;
      grant_q   <= 4'b0000;
      address_q <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      address_q <= address_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign address = address_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_decoder_arbiter
// Purpose  : Scoreboard bench for rr_decoder_arbiter against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_decoder_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [0:3] req;
  logic       done;
  logic [0:3] grant;
  logic [1:0] address;
  logic       busy;
  logic       timeout;

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .address (address),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:3] grant;
    logic [1:0] address;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: owner of -1 means nobody holds the fabric.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_addr  = 0;
  int   m_held  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [0:3] r, input logic d, input logic rs);
    exp_t e;
    int   idx;
    bit   normal;
    bit   limit;
    @(negedge clk);
    req   = r;
    done  = d;
    reset = rs;
    e.timeout = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_addr  = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_addr  = idx;
          m_held  = 1;
        end
      end
    end else begin
      normal = d || !r[m_owner];
      limit  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (normal || limit) begin
        e.timeout = limit && !normal;
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = -1;
      end else begin
        m_held++;
      end
    end
    e.grant = 4'b0000;
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;
    e.address = 2'(m_addr);
    e.busy    = (m_owner >= 0);
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT outputs after every edge for which a prediction exists.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("grant",   int'(grant),   int'(e.grant));
        check("address", int'(address), int'(e.address));
        check("busy",    int'(busy),    int'(e.busy));
        check("timeout", int'(timeout), int'(e.timeout));
        check("onehot",  int'($countones(grant) <= 1), 1);
        check("busy_vs_grant", int'(busy), int'(grant != 4'b0000));
      end
    end
  end

  initial begin
    logic [0:3] r;
    req   = 4'b0000;
    done  = 1'b0;
    reset = 1'b1;

    // Single requester, then done
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // ptr now 3: master 3 beats master 0
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b1, 1'b0);

    // All four requesting, done on second grant cycle
    step(4'b0000, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
    end

    // Hold limit with sustained request
    step(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) step(4'b0100, 1'b0, 1'b0);

    // done coinciding with the limit cycle
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Owner 3 drops while master 0 waits: pointer wraps
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);

    // Reset mid-grant
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b1, 1'b0);

    // Randomized traffic; requests mostly sticky so limits are reached
    r = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step(r, ($urandom_range(0, 6) == 0), ($urandom_range(0, 99) == 0));
    end
    step(4'b0000, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
